// File: rtl/pdf_key_search_ctrl.sv
// pdf_key_search_ctrl
// Sequencer for the brute-force PDF key search. It walks a window of
// candidate 128-bit keys and hands one to the decryptor per handshake. Keys in
// flight are remembered in a small FIFO so that each returned plaintext block
// can be tied back to its key. The first block that starts with "%PDF-1."
// stops the search. The controller then drains the keys still in flight and
// raises done.
//
// Optional feature macro: PDF_KEY_STRICT_VER_EN
//   When defined, a match also requires the version byte res_data[7:0] to be
//   ASCII '0'..'7'. When undefined, the version byte is ignored.

module pdf_key_search_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [127:0]     key_base,
  input  logic [CNT_W-1:0] key_count,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [127:0]     dec_key,
  input  logic             res_valid,
  input  logic [63:0]      res_data,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [127:0]     found_key,
  output logic [CNT_W-1:0] keys_tried,
  output logic             proto_err
);

  localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [55:0]     PDF_HDR = 56'h255044462D312E;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [127:0]     next_key_q, next_key_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [127:0]     mem_q [FIFO_DEPTH];
  logic [127:0]     mem_d [FIFO_DEPTH];
  logic             found_q, found_d;
  logic [127:0]     found_key_q, found_key_d;
  logic [CNT_W-1:0] keys_tried_q, keys_tried_d;
  logic             proto_err_q, proto_err_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             issue_ok;
  logic             push;
  logic             pop;
  logic [127:0]     head_key;
  logic             hdr_match;

  // Header recognition; the version byte only matters in strict builds
`ifdef PDF_KEY_STRICT_VER_EN
  assign hdr_match = (res_data[63:8] == PDF_HDR) &&
                     (res_data[7:0] >= 8'h30) && (res_data[7:0] <= 8'h37);
`else
  logic unused_ver_byte;
  assign hdr_match       = (res_data[63:8] == PDF_HDR);
  assign unused_ver_byte = ^res_data[7:0];
`endif

  // Occupancy comes from the registered count. A pop from a full FIFO
  // therefore frees the slot only in the following cycle, and the issue
  // valid never looks at dec_ready.
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign issue_ok   = (state_q == ST_RUN) && (remaining_q != '0) && !fifo_full;
  assign push       = issue_ok && dec_ready;
  assign pop        = res_valid && !fifo_empty;
  assign head_key   = mem_q[rd_ptr_q];

  assign dec_valid  = issue_ok;
  assign dec_key    = next_key_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign found      = found_q;
  assign found_key  = found_key_q;
  assign keys_tried = keys_tried_q;
  assign proto_err  = proto_err_q;

  // Next-state logic for the sequencer, the key FIFO and the result flags
  always_comb begin
    state_d      = state_q;
    next_key_d   = next_key_q;
    remaining_d  = remaining_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mem_d        = mem_q;
    found_d      = found_q;
    found_key_d  = found_key_q;
    keys_tried_d = keys_tried_q;
    proto_err_d  = proto_err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_key_d   = key_base;
          remaining_d  = key_count;
          found_d      = 1'b0;
          found_key_d  = '0;
          keys_tried_d = '0;
          proto_err_d  = 1'b0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        // Results are checked only while running. The first match wins, and
        // anything still in flight after it is discarded during drain.
        if (pop) begin
          keys_tried_d = keys_tried_q + CNT_W'(1);
          if (hdr_match) begin
            found_d     = 1'b1;
            found_key_d = head_key;
          end
        end
        if ((pop && hdr_match) || abort) begin
          state_d = ST_DRAIN;
        end else if ((remaining_q == '0) && fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An accepted key is recorded in the FIFO even on an abort cycle,
    // because the decryptor now owns it and will return a result for it.
    if (push) begin
      mem_d[wr_ptr_q] = next_key_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      next_key_d      = next_key_q + 128'd1;
      remaining_d     = remaining_q - CNT_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end

    if (res_valid && fifo_empty) begin
      proto_err_d = 1'b1;
    end
  end

  // State, FIFO and result registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      next_key_q   <= '0;
      remaining_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      found_q      <= 1'b0;
      found_key_q  <= '0;
      keys_tried_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_key_q   <= next_key_d;
      remaining_q  <= remaining_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
      found_q      <= found_d;
      found_key_q  <= found_key_d;
      keys_tried_q <= keys_tried_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_pdf_key_search_ctrl.sv
// Testbench for pdf_key_search_ctrl.
// The bench models the decryptor as an in-order queue of accepted keys. Each
// key comes back after a configurable latency. Expected search outcomes are
// derived from the candidate window and the set of keys that decrypt to a
// PDF header.

module tb_pdf_key_search_ctrl;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [127:0]     key_base;
  logic [CNT_W-1:0] key_count;
  logic             dec_valid;
  logic             dec_ready;
  logic [127:0]     dec_key;
  logic             res_valid;
  logic [63:0]      res_data;
  logic             busy;
  logic             done;
  logic             found;
  logic [127:0]     found_key;
  logic [CNT_W-1:0] keys_tried;
  logic             proto_err;

  pdf_key_search_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .key_base(key_base), .key_count(key_count),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_key(dec_key),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .found(found), .found_key(found_key),
    .keys_tried(keys_tried), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] base;
    logic [31:0]  cnt;
    int           lat;
    int           match_idx;
    logic [7:0]   ver;
    logic         exp_found;
    logic [127:0] exp_key;
    logic [31:0]  exp_tried;
    int           exp_issued;
    logic [127:0] exp_last;
  } vec_t;

  vec_t vecs [6];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [127:0] fl_key [$];
  int           fl_due [$];
  logic [127:0] match_keys [$];
  logic [7:0]   match_vers [$];

  int           issued, returned;
  logic [127:0] exp_next_key, last_issued, model_key;
  bit           matched, aborted, match_checked;
  int           ready_policy, release_budget, lat_cfg;
  bit           gap_en, inject_stray, start_req, abort_req;
  logic [127:0] req_base;
  logic [31:0]  req_count;
  logic         s_done, s_dec_valid;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic hdrMatch(input logic [63:0] d);
`ifdef PDF_KEY_STRICT_VER_EN
    return (d[63:8] == 56'h255044462D312E) && (d[7:0] >= 8'h30) && (d[7:0] <= 8'h37);
`else
    return (d[63:8] == 56'h255044462D312E);
`endif
  endfunction

  // Decrypted block the modelled decryptor returns for a key
  function automatic logic [63:0] respFor(input logic [127:0] k);
    for (int i = 0; i < match_keys.size(); i++) begin
      if (match_keys[i] == k) return {56'h255044462D312E, match_vers[i]};
    end
    return {8'h00, 24'($urandom), $urandom};
  endfunction

  // One clock: sample and check at the falling edge, drive the next inputs,
  // update the decryptor model, then advance past the rising edge
  task automatic applyStimulus();
    logic [127:0] k;
    logic [63:0]  d;
    @(negedge clk);
    s_done      = done;
    s_dec_valid = dec_valid;
    if (matched && !match_checked) begin
      checkOutput("found_after_match", found, 1'b1);
      checkOutput("found_key_after_match", found_key, model_key);
      match_checked = 1;
    end
    if (matched || aborted) checkOutput("dv_after_stop", dec_valid, 1'b0);
    if (dec_valid) begin
      checkOutput("dec_key_seq", dec_key, exp_next_key);
      checkOutput("fifo_room", fl_key.size() < FIFO_DEPTH, 1'b1);
    end
    start     = start_req;
    abort     = abort_req;
    key_base  = req_base;
    key_count = req_count;
    case (ready_policy)
      0:       dec_ready = 1'b0;
      1:       dec_ready = 1'b1;
      default: dec_ready = ($urandom_range(0, 3) != 0);
    endcase
    res_valid = 1'b0;
    res_data  = {8'h00, 24'($urandom), $urandom};
    if (inject_stray) begin
      res_valid = 1'b1;
      res_data  = 64'h0;
    end else if (fl_key.size() > 0 && fl_due[0] <= cyc && release_budget != 0 &&
                 !(gap_en && $urandom_range(0, 3) == 0)) begin
      k = fl_key.pop_front();
      void'(fl_due.pop_front());
      d = respFor(k);
      res_valid = 1'b1;
      res_data  = d;
      returned++;
      if (release_budget > 0) release_budget--;
      if (!matched && !aborted && hdrMatch(d)) begin
        matched   = 1;
        model_key = k;
      end
    end
    if (abort_req && busy) aborted = 1;
    if (dec_valid && dec_ready) begin
      fl_key.push_back(dec_key);
      fl_due.push_back(cyc + lat_cfg);
      issued++;
      last_issued  = dec_key;
      exp_next_key = exp_next_key + 128'd1;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic startSearch(input logic [127:0] base, input logic [31:0] cnt, input int lat);
    issued        = 0;
    returned      = 0;
    matched       = 0;
    aborted       = 0;
    match_checked = 0;
    exp_next_key  = base;
    last_issued   = '0;
    lat_cfg       = lat;
    req_base      = base;
    req_count     = cnt;
    start_req     = 1;
    applyStimulus();
    start_req     = 0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    s_done = 1'b0;
    while (!s_done && n < budget) begin
      applyStimulus();
      n++;
    end
    if (!s_done) checkOutput("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic checkSearch(input logic ef, input logic [127:0] ek, input logic [31:0] et,
                             input logic [31:0] cnt, input int ei, input logic [127:0] el);
    #1;
    checkOutput("done", done, 1'b1);
    checkOutput("busy_at_done", busy, 1'b0);
    checkOutput("found", found, ef);
    if (ef) checkOutput("found_key", found_key, ek);
    checkOutput("keys_tried", keys_tried, et);
    checkOutput("drained", fl_key.size(), 0);
    checkOutput("issue_limit", issued <= int'(cnt), 1'b1);
    if (ei >= 0) checkOutput("issued", issued, ei);
    if (ei > 0) checkOutput("last_issued", last_issued, el);
  endtask

  initial begin
    logic [127:0] base, k, ek;
    logic [31:0]  cnt, et;
    logic         ef;
    int           lat, nm, n;

    // Directed search table; expectations worked out by hand
    vecs[0] = '{128'h10, 32'd5, 3, -1, 8'h00, 1'b0, 128'h0, 32'd5, 5, 128'h14};
    vecs[1] = '{128'h10, 32'd5, 3, 2, 8'h35, 1'b1, 128'h12, 32'd3, 5, 128'h14};
    vecs[2] = '{{128{1'b1}}, 32'd2, 2, -1, 8'h00, 1'b0, 128'h0, 32'd2, 2, 128'h0};
    vecs[3] = '{128'h300, 32'd0, 2, -1, 8'h00, 1'b0, 128'h0, 32'd0, 0, 128'h0};
`ifdef PDF_KEY_STRICT_VER_EN
    vecs[4] = '{128'h40, 32'd4, 3, 1, 8'h39, 1'b0, 128'h0, 32'd4, 4, 128'h43};
`else
    vecs[4] = '{128'h40, 32'd4, 3, 1, 8'h39, 1'b1, 128'h41, 32'd2, -1, 128'h0};
`endif
    vecs[5] = '{128'h100, 32'd3, 1, 0, 8'h30, 1'b1, 128'h100, 32'd1, -1, 128'h0};

    rst_n = 1'b0; start = 0; abort = 0; key_base = '0; key_count = '0;
    dec_ready = 0; res_valid = 0; res_data = '0;
    issued = 0; returned = 0; matched = 0; aborted = 0; match_checked = 0;
    exp_next_key = '0; last_issued = '0; model_key = '0;
    ready_policy = 1; release_budget = -1; lat_cfg = 1; gap_en = 0;
    inject_stray = 0; start_req = 0; abort_req = 0; req_base = '0; req_count = '0;
    s_done = 0; s_dec_valid = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dec_valid", dec_valid, 1'b0);
    checkOutput("rst_dec_key", dec_key, 128'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_found", found, 1'b0);
    checkOutput("rst_found_key", found_key, 128'h0);
    checkOutput("rst_keys_tried", keys_tried, 32'h0);
    checkOutput("rst_proto_err", proto_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven searches
    foreach (vecs[i]) begin
      match_keys.delete();
      match_vers.delete();
      if (vecs[i].match_idx >= 0) begin
        match_keys.push_back(vecs[i].base + 128'(vecs[i].match_idx));
        match_vers.push_back(vecs[i].ver);
      end
      ready_policy = 1; gap_en = 0; release_budget = -1;
      startSearch(vecs[i].base, vecs[i].cnt, vecs[i].lat);
      #1;
      checkOutput("busy_after_start", busy, 1'b1);
      waitDone(500);
      checkSearch(vecs[i].exp_found, vecs[i].exp_key, vecs[i].exp_tried, vecs[i].cnt,
                  vecs[i].exp_issued, vecs[i].exp_last);
    end

    // Back-pressure: no issue while dec_ready is low, then the FIFO fills
    // to its depth while results are withheld
    match_keys.delete(); match_vers.delete();
    ready_policy = 0; release_budget = 0; gap_en = 0;
    startSearch(128'hA000, 32'd20, 2);
    repeat (5) applyStimulus();
    #1;
    checkOutput("no_push_ready0", issued, 0);
    checkOutput("dv_held_ready0", dec_valid, 1'b1);
    req_base = 128'hBEEF;
    start_req = 1;
    applyStimulus();
    start_req = 0;
    ready_policy = 1;
    repeat (15) applyStimulus();
    #1;
    checkOutput("fill_issued", issued, FIFO_DEPTH);
    checkOutput("full_dv_low", dec_valid, 1'b0);
    checkOutput("full_busy", busy, 1'b1);
    release_budget = 1;
    applyStimulus();
    checkOutput("pop_cycle_still_full", s_dec_valid, 1'b0);
    #1;
    checkOutput("slot_freed_next", dec_valid, 1'b1);
    release_budget = -1;
    waitDone(500);
    checkSearch(1'b0, 128'h0, 32'd20, 32'd20, 20, 128'hA000 + 128'd19);

    // Abort after two issues with nothing returned
    ready_policy = 1; release_budget = 0;
    startSearch(128'h500, 32'd10, 2);
    n = 0;
    while (issued < 2 && n < 50) begin
      applyStimulus();
      n++;
    end
    ready_policy = 0;
    abort_req = 1;
    applyStimulus();
    abort_req = 0;
    ready_policy = 1;
    repeat (5) applyStimulus();
    #1;
    checkOutput("abort_busy", busy, 1'b1);
    release_budget = -1;
    waitDone(200);
    checkSearch(1'b0, 128'h0, 32'd0, 32'd10, 2, 128'h501);
    abort_req = 1;
    applyStimulus();
    abort_req = 0;
    applyStimulus();
    #1;
    checkOutput("abort_in_done_ignored", done, 1'b1);

    // Stray result with an empty FIFO
    ready_policy = 0;
    startSearch(128'h700, 32'd3, 1);
    applyStimulus();
    inject_stray = 1;
    applyStimulus();
    inject_stray = 0;
    #1;
    checkOutput("proto_err_set", proto_err, 1'b1);
    checkOutput("stray_not_counted", keys_tried, 32'd0);
    ready_policy = 1;
    waitDone(200);
    checkSearch(1'b0, 128'h0, 32'd3, 32'd3, 3, 128'h702);
    checkOutput("proto_err_sticky", proto_err, 1'b1);

    // Empty window: one cycle in RUN, then DONE
    startSearch(128'h800, 32'd0, 1);
    #1;
    checkOutput("proto_err_cleared", proto_err, 1'b0);
    checkOutput("zero_busy", busy, 1'b1);
    checkOutput("zero_no_issue", dec_valid, 1'b0);
    applyStimulus();
    checkOutput("zero_not_done_yet", s_done, 1'b0);
    applyStimulus();
    checkOutput("zero_done", s_done, 1'b1);
    checkSearch(1'b0, 128'h0, 32'd0, 32'd0, 0, 128'h0);

    // Randomized searches against the window model
    for (int t = 0; t < 30; t++) begin
      base = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        base = '1;
        base = base - 128'($urandom_range(0, 5));
      end
      cnt = 32'($urandom_range(0, 25));
      lat = $urandom_range(1, 12);
      nm  = $urandom_range(0, 2);
      match_keys.delete();
      match_vers.delete();
      if (cnt > 0) begin
        for (int m = 0; m < nm; m++) begin
          match_keys.push_back(base + 128'($urandom_range(0, int'(cnt) - 1)));
          match_vers.push_back(8'h30 + 8'($urandom_range(0, 9)));
        end
      end
      ef = 1'b0; ek = '0; et = cnt;
      for (int i = 0; i < int'(cnt); i++) begin
        k = base + 128'(i);
        if (!ef && hdrMatch(respFor(k))) begin
          ef = 1'b1;
          ek = k;
          et = 32'(i + 1);
        end
      end
      ready_policy = 2; gap_en = 1; release_budget = -1;
      startSearch(base, cnt, lat);
      waitDone(3000);
      checkSearch(ef, ek, et, cnt, ef ? -1 : int'(cnt), base + 128'(cnt) - 128'd1);
    end

    // Asynchronous reset in the middle of a search
    match_keys.delete(); match_vers.delete();
    ready_policy = 1; gap_en = 0;
    startSearch(128'h900, 32'd20, 3);
    repeat (4) applyStimulus();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", busy, 1'b0);
    checkOutput("async_rst_dv", dec_valid, 1'b0);
    checkOutput("async_rst_tried", keys_tried, 32'h0);
    fl_key.delete();
    fl_due.delete();
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pdf_key_search_ctrl.md
# pdf_key_search_ctrl

Sequencer for the brute-force PDF key search. It walks a window of candidate 128-bit keys and issues one candidate per handshake to the decryption datapath. It buffers the keys in flight and checks each returned 64-bit plaintext block for the `%PDF-1.` header. It reports the first matching key, then drains the pipeline and signals completion; it sits between the host/config layer and the decryptor core.

## Interface
- `FIFO_DEPTH`, 8: max keys in flight inside the decryptor; power of 2, ≥2.
- `CNT_W`, 32: width of key count and tried counter.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; begin search (ignored unless IDLE or DONE).
- `abort` in 1: stop issuing, drain, finish without further checks.
- `key_base` in 128: first candidate key, sampled on accepted `start`.
- `key_count` in CNT_W: number of candidates, sampled on accepted `start`.
- `dec_valid` out 1: candidate key presented.
- `dec_ready` in 1: decryptor accepts key this cycle.
- `dec_key` out 128: candidate key.
- `res_valid` in 1: decrypted block returned (in issue order).
- `res_data` in 64: decrypted first block.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: high in DONE until next accepted `start`.
- `found` out 1: a match was seen in this search.
- `found_key` out 128: matching key, valid when `found`.
- `keys_tried` out CNT_W: results checked in this search.
- `proto_err` out 1: sticky; `res_valid` arrived with no key in flight.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + `start`:
  - Load `next_key`=`key_base`, `remaining`=`key_count`.
  - Clear `found`, `found_key`, `keys_tried`, `proto_err`, `done`.
  - Go to RUN.
- RUN issue:
  - `dec_valid` = (`remaining`≠0) && key FIFO not full; `dec_key`=`next_key`.
  - On `dec_valid && dec_ready`: push `next_key` into FIFO, `next_key`+=1 (mod 2^128), `remaining`-=1.
- Result check, in RUN only:
  - On `res_valid`: pop FIFO head, `keys_tried`+=1.
  - Match when `res_data[63:8]` == 56'h255044462D312E ("%PDF-1.").
  - On match: `found`=1, `found_key`=popped key, go to DRAIN.
- RUN → DRAIN on match or `abort`. RUN → DONE when `remaining`==0 and FIFO empty with no push/pop this cycle.
- DRAIN:
  - `dec_valid`=0.
  - Each `res_valid` pops and discards; no check, no `keys_tried` increment.
  - → DONE when FIFO empty.
- DONE: `done`=1; `found`/`found_key`/`keys_tried` held.
- Push and pop in the same cycle: both occur, occupancy unchanged; a pop from a full FIFO frees the slot in the following cycle only.
- `res_valid` with FIFO empty: ignored, `proto_err`=1.
- `key_count`=0: RUN exits to DONE after one cycle, `found`=0, no issue.
- `abort` in IDLE/DONE: ignored. `start` in RUN/DRAIN: ignored.
- First match in issue order wins; later results are never checked.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, and all of the following are 0:
  - `dec_valid`, `dec_key`, `busy`, `done`, `found`, `found_key`, `keys_tried`, `proto_err`.
- `rst_n` low mid-search: in-flight keys are lost; the decryptor must be reset alongside.
- `dec_valid`/`dec_key` are driven from registers only and do not depend on `dec_ready` in the same cycle.
- `start` accepted at edge N: `busy`=1 and `dec_valid` may be 1 after edge N.
- Match on `res_valid` at edge N:
  - `found`/`found_key` are visible after edge N.
  - `dec_valid` is 0 from the cycle after edge N.
- `done` rises the cycle after the FIFO becomes empty in DRAIN, or after the RUN exit condition.
- Sustained throughput: one key per cycle while `dec_ready`=1 and results return within FIFO_DEPTH cycles.

## Configuration
- `PDF_KEY_STRICT_VER_EN` defined:
  - A match additionally requires `res_data[7:0]` in ASCII '0'..'7' (8'h30..8'h37).
  - A header with any other version byte is counted in `keys_tried` and not matched.
- Not defined: `res_data[7:0]` is ignored.

## Test plan
- `key_base`=0x10, `key_count`=5, `dec_ready`=1, return latency 3:
  - Results for keys 0x10..0x14 return `res_data`=0.
  - Expect 5 issues, `done`=1, `found`=0, `keys_tried`=5.
- Same setup, third result = 64'h255044462D312E35:
  - `found`=1, `found_key`=0x12, `keys_tried`=3.
  - Keys 0x13/0x14 issued before the match are drained; `done` follows the last pop.
- `dec_ready` held 0, then results withheld:
  - No push while `dec_ready`=0.
  - With `dec_ready`=1 and results withheld, exactly FIFO_DEPTH=8 issues, then `dec_valid`=0 until a pop.
- `key_base`=2^128−1, `key_count`=2: issued keys are 0xFFFF…FFFF then 0x0.
- `abort` after 2 issues with none returned: no further `dec_valid`; the 2 results are discarded; `done`=1, `found`=0, `keys_tried`=0.
- `res_valid` in RUN with the FIFO empty: `proto_err`=1, `keys_tried` unchanged.
- With `PDF_KEY_STRICT_VER_EN`, result `res_data[7:0]`=8'h39 (other bytes = header): no match.
